// File: rtl/uart_word_sender.sv
// Breaks an NB_WORD word into NB_DATA bytes, LSB first, and hands them to a uart transmitter.
// Define UART_WORD_CHECKSUM_EN to append a trailing XOR checksum byte to each word.
module uart_word_sender #(
  parameter int NB_WORD = 32,
  parameter int NB_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_word_valid,
  input  logic [NB_WORD-1:0] i_word,
  output logic               o_word_ready,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done_tick,
  output logic               o_word_sent,
  output logic               o_busy
);

  localparam int unsigned NBYTES = NB_WORD / NB_DATA;
`ifdef UART_WORD_CHECKSUM_EN
  localparam int unsigned TOTAL = NBYTES + 1;
`else
  localparam int unsigned TOTAL = NBYTES;
`endif
  localparam int unsigned CW = $clog2(NBYTES + 2);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, FINISH} state_t;

  state_t             state;
  logic [NB_WORD-1:0] shreg;
  logic [NB_WORD-1:0] shifted;
  logic [CW-1:0]      cnt;
`ifdef UART_WORD_CHECKSUM_EN
  logic [NB_DATA-1:0] csum;
`endif

  assign shifted = shreg >> NB_DATA;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_word_sent  <= 1'b0;
      o_busy       <= 1'b0;
      o_word_ready <= 1'b1;
`ifdef UART_WORD_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      o_tx_start  <= 1'b0;
      o_word_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (i_word_valid && o_word_ready) begin
            shreg        <= i_word;
            cnt          <= '0;
            o_tx_data    <= i_word[NB_DATA-1:0];
            o_tx_start   <= 1'b1;
            o_word_ready <= 1'b0;
            o_busy       <= 1'b1;
`ifdef UART_WORD_CHECKSUM_EN
            csum         <= '0;
`endif
            state        <= START;
          end
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (i_tx_done_tick) begin
`ifdef UART_WORD_CHECKSUM_EN
            csum <= csum ^ o_tx_data;
`endif
            if (cnt == CW'(TOTAL - 1)) begin
              o_word_sent <= 1'b1;
              state       <= FINISH;
            end else begin
              cnt        <= cnt + CW'(1);
              shreg      <= shifted;
              o_tx_start <= 1'b1;
`ifdef UART_WORD_CHECKSUM_EN
              // after the last data byte the running XOR (incl. that byte) becomes the payload
              o_tx_data  <= (cnt == CW'(NBYTES - 1)) ? (csum ^ o_tx_data)
                                                     : shifted[NB_DATA-1:0];
`else
              o_tx_data  <= shifted[NB_DATA-1:0];
`endif
              state      <= START;
            end
          end
        end
        FINISH: begin
          o_busy       <= 1'b0;
          o_word_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: vector table of words, byte scoreboard, and
// hand-written sequences for reset, spurious ticks and back-to-back words.
module tb_uart_word_sender;

`ifdef UART_WORD_CHECKSUM_EN
  localparam int NSEND = 5;
`else
  localparam int NSEND = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        word_valid = 1'b0;
  logic [31:0] word = '0;
  logic        word_ready, tx_start, word_sent, busy;
  logic [7:0]  tx_data;
  logic        tx_done_tick;
  logic        model_en = 1'b0;
  logic        model_tick = 1'b0;
  logic        manual_tick = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          starts = 0;
  int          sents = 0;
  int          timer = 0;
  logic [7:0]  sb[$];
  logic [7:0]  last_byte = '0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] seq;   // expected bytes in send order, first byte in [31:24]
  } vec_t;
  vec_t vecs[5];

  assign tx_done_tick = model_tick | manual_tick;

  uart_word_sender #(.NB_WORD(32), .NB_DATA(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_word_valid   (word_valid),
    .i_word         (word),
    .o_word_ready   (word_ready),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .i_tx_done_tick (tx_done_tick),
    .o_word_sent    (word_sent),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor pops the scoreboard on each start; tx model answers each start with a done tick 10 cycles later.
  always @(negedge clk) begin
    if (tx_start) begin
      starts++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got byte %h expected no start at %0t", tx_data, $time);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
      last_byte = tx_data;
    end
    if (word_sent) sents++;

    model_tick = 1'b0;
    if (!model_en) begin
      timer = 0;
    end else begin
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          model_tick = 1'b1;
          check("tx_data_stable", {24'h0, tx_data}, {24'h0, last_byte});
        end
      end
      if (tx_start) timer = 10;
    end
  end

  task automatic push_expected(input logic [31:0] seq);
    logic [7:0] cs = '0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(seq[31-8*i -: 8]);
      cs ^= seq[31-8*i -: 8];
    end
`ifdef UART_WORD_CHECKSUM_EN
    sb.push_back(cs);
`endif
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] seq, input bit keep);
    int i;
    word       = w;
    word_valid = 1'b1;
    for (i = 0; i < 300; i++) begin
      if (word_ready) break;
      @(negedge clk);
    end
    if (i == 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready 0 expected 1 at %0t", $time);
    end
    push_expected(seq);
    @(negedge clk);
    if (!keep) word_valid = 1'b0;
  endtask

  task automatic wait_sent();
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (word_sent) break;
    end
    if (i == 500) begin
      checks++;
      errors++;
      $display("FAIL sent_timeout: got word_sent 0 expected 1 at %0t", $time);
    end
  endtask

  initial begin
    int s0, n0, s1;
    vecs[0] = '{32'h12345678, 32'h78563412};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{32'h00000000, 32'h00000000};
    vecs[3] = '{32'h80000001, 32'h01000080};
    vecs[4] = '{32'hA5C3_0F69, 32'h690FC3A5};

    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_word_sent", {31'h0, word_sent}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, word_ready}, 32'h1);

    model_en = 1'b1;
    foreach (vecs[k]) begin
      s0 = starts;
      n0 = sents;
      send_word(vecs[k].word, vecs[k].seq, 1'b0);
      check("busy_during_word", {31'h0, busy}, 32'h1);
      check("not_ready_during_word", {31'h0, word_ready}, 32'h0);
      wait_sent();
      @(negedge clk);
      check("ready_after_word", {31'h0, word_ready}, 32'h1);
      check("idle_not_busy", {31'h0, busy}, 32'h0);
      check("start_count", starts - s0, NSEND);
      check("sent_count", sents - n0, 1);
      check("sb_empty", sb.size(), 0);
    end

    // Back-to-back: valid stays high, second word must wait for the first to finish.
    s0 = starts;
    n0 = sents;
    send_word(32'hDEADBEEF, 32'hEFBEADDE, 1'b1);
    send_word(32'h01020304, 32'h04030201, 1'b0);
    check("b2b_second_after_sent", sents - n0, 1);
    wait_sent();
    @(negedge clk);
    check("b2b_start_count", starts - s0, 2 * NSEND);
    check("b2b_sent_count", sents - n0, 2);
    check("b2b_sb_empty", sb.size(), 0);

    // Spurious ticks in IDLE and on the START cycle, then manual tick timing.
    model_en = 1'b0;
    @(negedge clk);
    manual_tick = 1'b1;
    @(negedge clk);
    manual_tick = 1'b0;
    check("idle_tick_busy", {31'h0, busy}, 32'h0);
    check("idle_tick_ready", {31'h0, word_ready}, 32'h1);
    check("idle_tick_start", {31'h0, tx_start}, 32'h0);
    s0 = starts;
    send_word(32'hCAFEF00D, 32'h0DF0FECA, 1'b0);
    check("start_cycle", {31'h0, tx_start}, 32'h1);
    manual_tick = 1'b1;
    @(negedge clk);
    manual_tick = 1'b0;
    check("start_tick_ignored", {31'h0, tx_start}, 32'h0);
    repeat (5) @(negedge clk);
    check("start_tick_no_restart", starts - s0, 1);
    check("start_tick_busy", {31'h0, busy}, 32'h1);
    for (int b = 1; b < NSEND; b++) begin
      manual_tick = 1'b1;
      @(negedge clk);
      manual_tick = 1'b0;
      check("start_after_tick", {31'h0, tx_start}, 32'h1);
      @(negedge clk);
    end
    manual_tick = 1'b1;
    @(negedge clk);
    manual_tick = 1'b0;
    check("finish_sent", {31'h0, word_sent}, 32'h1);
    @(negedge clk);
    check("finish_ready", {31'h0, word_ready}, 32'h1);
    check("manual_start_count", starts - s0, NSEND);

    // Reset during WAIT_DONE of the second byte abandons the word.
    model_en = 1'b1;
    s0 = starts;
    send_word(32'h11223344, 32'h44332211, 1'b0);
    for (int i = 0; i < 100 && (starts - s0) < 2; i++) @(negedge clk);
    check("mid_word_reached_byte2", starts - s0, 2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_word_sent", {31'h0, word_sent}, 32'h0);
    check("async_rst_tx_data", {24'h0, tx_data}, 32'h0);
    model_en = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    s1 = starts;
    repeat (30) @(negedge clk);
    check("no_start_after_rst", starts - s1, 0);
    check("ready_after_mid_rst", {31'h0, word_ready}, 32'h1);
    model_en = 1'b1;
    s0 = starts;
    send_word(32'h000000AA, 32'hAA000000, 1'b0);
    wait_sent();
    @(negedge clk);
    check("post_rst_start_count", starts - s0, NSEND);
    check("post_rst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/uart_word_sender.md
UART_WORD_SENDER -- requirements
Module: uart_word_sender

Interface
REQ-001 Parameter NB_WORD, default 32: width of the word accepted from the MIPS side.
REQ-002 Parameter NB_DATA, default 8: UART byte width; NB_WORD SHALL be an integer multiple of NB_DATA.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_word_valid  input  1  word offered for transmission.
REQ-006 i_word  input  NB_WORD  word to transmit.
REQ-007 o_word_ready  output  1  block can accept a word this cycle.
REQ-008 o_tx_start  output  1  one-cycle start pulse to the uart transmitter.
REQ-009 o_tx_data  output  NB_DATA  byte presented to the uart transmitter.
REQ-010 i_tx_done_tick  input  1  uart transmitter finished the current byte, including its stop bit.
REQ-011 o_word_sent  output  1  one-cycle pulse after the last byte of a word completes.
REQ-012 o_busy  output  1  high whenever not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, START, WAIT_DONE and FINISH.
REQ-014 In IDLE, o_word_ready SHALL be 1; a word is accepted when i_word_valid and o_word_ready are both 1 in the same cycle.
- On acceptance, i_word is latched into a shift register, the byte counter clears, and the FSM goes to START.
REQ-015 In START, o_tx_start SHALL be 1 for exactly one cycle with o_tx_data = current byte; next state is WAIT_DONE.
- First o_tx_start occurs the cycle after acceptance.
REQ-016 Bytes SHALL be sent least-significant byte first: NB_WORD/NB_DATA bytes per word.
REQ-017 o_tx_data SHALL stay stable from START until the i_tx_done_tick of that byte.
REQ-018 In WAIT_DONE, when i_tx_done_tick = 1:
- if bytes remain, the shift register shifts by NB_DATA, the counter increments, and the FSM enters START, so the next o_tx_start is exactly one cycle after the done tick;
- after the last byte, the FSM enters FINISH.
REQ-019 In FINISH, o_word_sent SHALL be 1 for one cycle; the FSM then returns to IDLE, and o_word_ready is 1 the following cycle.
REQ-020 i_tx_done_tick SHALL be ignored in IDLE, START and FINISH.
- A tick coinciding with the START cycle does not count as completion.
REQ-021 i_word_valid and i_word SHALL be ignored outside IDLE; no word is queued.
REQ-022 The byte counter SHALL be wide enough for NB_WORD/NB_DATA+1 and SHALL never wrap within a word.

Reset
REQ-023 On i_rst, the FSM SHALL go to IDLE immediately, regardless of clock.
- o_tx_start, o_word_sent and o_busy reset to 0.
- o_tx_data, the shift register and the counter reset to 0.
- o_word_ready is 1 once i_rst deasserts.
REQ-024 Reset mid-word SHALL abandon the remaining bytes; after reset no further o_tx_start is issued for the abandoned word.

Configuration
REQ-025 Macro UART_WORD_CHECKSUM_EN:
- when defined, after the last data byte, one extra byte equal to the XOR of all data bytes SHALL be sent through the same START/WAIT_DONE sequence before FINISH;
- when undefined, no checksum byte is sent and the checksum logic is absent.

Verification
REQ-026 Reset mid-stream: assert i_rst during WAIT_DONE of byte 2 -> all outputs at reset values immediately; no further o_tx_start; next word 0x000000AA sends 0xAA first.
REQ-027 Basic word, no checksum: word 0x12345678 accepted, tx model returns done 10 cycles after each start -> o_tx_data sequence 0x78, 0x56, 0x34, 0x12; four start pulses; o_word_sent once; o_word_ready back high.
REQ-028 Checksum build: word 0x12345678 with UART_WORD_CHECKSUM_EN -> five bytes 0x78, 0x56, 0x34, 0x12, 0x08.
REQ-029 Back-to-back handshake: i_word_valid held high with 0xDEADBEEF then 0x01020304 -> second word accepted only in IDLE after o_word_sent; bytes 0xEF, 0xBE, 0xAD, 0xDE, 0x04, 0x03, 0x02, 0x01.
REQ-030 Spurious ticks: i_tx_done_tick pulsed in IDLE and during the START cycle -> no state change; byte count is unaffected.
REQ-031 Done tick timing: done tick in cycle N -> o_tx_start in cycle N+1 with the next byte valid.
